// File: rtl/mesh_endpoint.sv
// Mesh-side tile link termination: TX FIFO (tile->router) and RX FIFO (router->tile).

// Circular show-ahead FIFO; head is read combinationally from storage.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on o_full/o_empty.
module mesh_endpoint_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   i_push_vld,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop_vld,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    w_count;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB makes the difference distinguish full from empty after wrap.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign o_count    = w_count;
  assign o_full     = (w_count == PW'(DEPTH));
  assign o_empty    = (w_count == '0);
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[PW-2:0]];
  assign w_push     = i_push_vld & ~o_full;
  assign w_pop      = i_pop_vld & ~o_empty;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[PW-2:0]] <= i_push_dat;
        r_wr_ptr                <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end
endmodule

// Tile<->router endpoint: tile words captured into TX via an IDLE/ACK handshake, RX delivered show-ahead.
// Latency: send_done the cycle after capture; TX/RX words reach the far side the cycle after push.
// Backpressure: TX full holds the tile (no send_done); RX full drops net_in_ready; router stalls TX pop.
module mesh_endpoint #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [WIDTH-1:0]       send_data,
  input  logic                   send_ready,
  output logic                   send_done,
  output logic [WIDTH-1:0]       recv_data,
  output logic                   recv_valid,
  input  logic                   recv_ready,
  output logic [WIDTH-1:0]       net_out_data,
  output logic                   net_out_valid,
  input  logic                   net_out_ready,
  input  logic [WIDTH-1:0]       net_in_data,
  input  logic                   net_in_valid,
  output logic                   net_in_ready,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count
);
  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t r_state;
  logic   r_send_done;
  logic   r_in_live;
  logic   w_tx_full;
  logic   w_tx_empty;
  logic   w_tx_push;
  logic   w_tx_pop;
  logic   w_rx_full;
  logic   w_rx_empty;
  logic   w_rx_push;
  logic   w_rx_pop;

  // Fullness is sampled before the edge, so a pop from a full TX cannot admit a capture that cycle.
  assign w_tx_push     = (r_state == ST_IDLE) & send_ready & ~w_tx_full;
  assign w_tx_pop      = ~w_tx_empty & net_out_ready;
  assign net_out_valid = ~w_tx_empty;
  assign send_done     = r_send_done;

  // r_in_live keeps net_in_ready low through reset and rises on the first edge after release.
  assign net_in_ready  = r_in_live & ~w_rx_full;
  assign w_rx_push     = net_in_valid & net_in_ready;
  assign recv_valid    = ~w_rx_empty;
  assign w_rx_pop      = recv_valid & recv_ready;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= ST_IDLE;
      r_send_done <= 1'b0;
      r_in_live   <= 1'b0;
    end else begin
      r_in_live <= 1'b1;
      if (r_state == ST_IDLE) begin
        r_send_done <= w_tx_push;
        if (w_tx_push) begin
          r_state <= ST_ACK;
        end
      end else begin
        r_send_done <= 1'b0;
        r_state     <= ST_IDLE;
      end
    end
  end

  mesh_endpoint_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_push_vld (w_tx_push),
    .i_push_dat (send_data),
    .i_pop_vld  (w_tx_pop),
    .o_head_dat (net_out_data),
    .o_full     (w_tx_full),
    .o_empty    (w_tx_empty),
    .o_count    (tx_count)
  );

  mesh_endpoint_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .CLK        (CLK),
    .nRST       (nRST),
    .i_push_vld (w_rx_push),
    .i_push_dat (net_in_data),
    .i_pop_vld  (w_rx_pop),
    .o_head_dat (recv_data),
    .o_full     (w_rx_full),
    .o_empty    (w_rx_empty),
    .o_count    (rx_count)
  );
endmodule

// File: tb/tb_mesh_endpoint.sv
// Directed bench for mesh_endpoint (WIDTH=32, DEPTH=4).
module tb_mesh_endpoint;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic [WIDTH-1:0]  send_data = '0;
  logic              send_ready = 1'b0;
  logic              send_done;
  logic [WIDTH-1:0]  recv_data;
  logic              recv_valid;
  logic              recv_ready = 1'b0;
  logic [WIDTH-1:0]  net_out_data;
  logic              net_out_valid;
  logic              net_out_ready = 1'b0;
  logic [WIDTH-1:0]  net_in_data = '0;
  logic              net_in_valid = 1'b0;
  logic              net_in_ready;
  logic [2:0]        tx_count;
  logic [2:0]        rx_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  mesh_endpoint #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .send_data     (send_data),
    .send_ready    (send_ready),
    .send_done     (send_done),
    .recv_data     (recv_data),
    .recv_valid    (recv_valid),
    .recv_ready    (recv_ready),
    .net_out_data  (net_out_data),
    .net_out_valid (net_out_valid),
    .net_out_ready (net_out_ready),
    .net_in_data   (net_in_data),
    .net_in_valid  (net_in_valid),
    .net_in_ready  (net_in_ready),
    .tx_count      (tx_count),
    .rx_count      (rx_count)
  );

  // Outputs are sampled and inputs changed 1ns after each rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] flags;
    repeat (2) @(posedge CLK);
    #1;
    flags = {send_done, recv_valid, net_out_valid, net_in_ready, (recv_data != 0), (net_out_data != 0),
             (tx_count != 0), (rx_count != 0)};
    n_vec++;
    if (flags !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: got flags %b, expected 00000000", flags);
    end
    @(negedge CLK);
    nRST = 1'b1;
    n_vec++;
    if (net_in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_ready_low: got %b, expected 0", net_in_ready);
    end
    tick();
    n_vec++;
    if (net_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_ready_high: got %b, expected 1", net_in_ready);
    end
  endtask

  task automatic test_single_send;
    send_data  = 32'hDEADBEEF;
    send_ready = 1'b1;
    tick();
    n_vec++;
    if ({send_done, net_out_valid, tx_count} !== {1'b1, 1'b1, 3'd1} || net_out_data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_send: done=%b vld=%b cnt=%0d dat=%h, expected 1 1 1 deadbeef",
               send_done, net_out_valid, tx_count, net_out_data);
    end
    send_ready = 1'b0;
    tick();
    n_vec++;
    if (send_done !== 1'b0 || tx_count !== 3'd1) begin
      n_err++;
      $display("FAIL single_send_pulse: done=%b cnt=%0d, expected 0 1", send_done, tx_count);
    end
    net_out_ready = 1'b1;
    tick();
    net_out_ready = 1'b0;
    n_vec++;
    if (tx_count !== 3'd0 || net_out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_send_drain: cnt=%0d vld=%b, expected 0 0", tx_count, net_out_valid);
    end
  endtask

  task automatic test_tx_backpressure;
    int pulses = 0;
    int exp_out = 1;
    int late_done = 0;
    net_out_ready = 1'b0;
    send_data  = 32'd1;
    send_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (send_done) begin
        pulses++;
        send_data = send_data + 1;
      end
    end
    n_vec++;
    if (pulses != 4 || tx_count !== 3'd4 || send_done !== 1'b0 || net_out_data !== 32'd1) begin
      n_err++;
      $display("FAIL tx_full_hold: pulses=%0d cnt=%0d done=%b head=%h, expected 4 4 0 1",
               pulses, tx_count, send_done, net_out_data);
    end
    net_out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_out <= 5; c++) begin
      if (net_out_valid) begin
        n_vec++;
        if (net_out_data !== WIDTH'(exp_out)) begin
          n_err++;
          $display("FAIL tx_order: got %h, expected %h", net_out_data, exp_out);
        end
        exp_out++;
      end
      tick();
      if (send_done) begin
        late_done++;
        send_ready = 1'b0;
      end
    end
    net_out_ready = 1'b0;
    n_vec++;
    if (exp_out != 6 || late_done != 1 || tx_count !== 3'd0) begin
      n_err++;
      $display("FAIL tx_drain: next=%0d dones=%0d cnt=%0d, expected 6 1 0", exp_out, late_done, tx_count);
    end
  endtask

  task automatic test_rx_path;
    int k = 0;
    logic acc;
    recv_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      net_in_valid = (k < 5);
      net_in_data  = 32'hA0 + k;
      acc = net_in_valid & net_in_ready;
      tick();
      if (acc) k++;
    end
    n_vec++;
    if (k != 4 || net_in_ready !== 1'b0 || rx_count !== 3'd4 || recv_data !== 32'hA0) begin
      n_err++;
      $display("FAIL rx_full: pushed=%0d rdy=%b cnt=%0d head=%h, expected 4 0 4 a0",
               k, net_in_ready, rx_count, recv_data);
    end
    recv_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n_vec++;
      if (recv_valid !== 1'b1 || recv_data !== 32'hA0 + j) begin
        n_err++;
        $display("FAIL rx_order: vld=%b dat=%h, expected 1 %h", recv_valid, recv_data, 32'hA0 + j);
      end
      acc = net_in_valid & net_in_ready;
      tick();
      if (acc) begin
        k++;
        if (k == 5) net_in_valid = 1'b0;
      end
    end
    recv_ready = 1'b0;
    n_vec++;
    if (rx_count !== 3'd0 || recv_valid !== 1'b0 || recv_data !== 32'h0) begin
      n_err++;
      $display("FAIL rx_empty: cnt=%0d vld=%b dat=%h, expected 0 0 0", rx_count, recv_valid, recv_data);
    end
  endtask

  task automatic test_rx_concurrent;
    recv_ready   = 1'b0;
    net_in_valid = 1'b1;
    net_in_data  = 32'hB0;
    tick();
    net_in_data  = 32'hB1;
    tick();
    n_vec++;
    if (rx_count !== 3'd2) begin
      n_err++;
      $display("FAIL rx_conc_pre: cnt=%0d, expected 2", rx_count);
    end
    recv_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      net_in_data = 32'hB2 + i;
      n_vec++;
      if (recv_data !== 32'hB0 + i || net_in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rx_conc_data: dat=%h rdy=%b, expected %h 1", recv_data, net_in_ready, 32'hB0 + i);
      end
      tick();
      n_vec++;
      if (rx_count !== 3'd2) begin
        n_err++;
        $display("FAIL rx_conc_count: cnt=%0d, expected 2", rx_count);
      end
    end
    net_in_valid = 1'b0;
    for (int i = 10; i < 12; i++) begin
      n_vec++;
      if (recv_data !== 32'hB0 + i) begin
        n_err++;
        $display("FAIL rx_conc_tail: dat=%h, expected %h", recv_data, 32'hB0 + i);
      end
      tick();
    end
    recv_ready = 1'b0;
    n_vec++;
    if (rx_count !== 3'd0) begin
      n_err++;
      $display("FAIL rx_conc_end: cnt=%0d, expected 0", rx_count);
    end
  endtask

  task automatic test_back_to_back;
    int caps = 0;
    int exp_out = 32'h100;
    net_out_ready = 1'b1;
    send_data  = 32'h100;
    send_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (net_out_valid) begin
        n_vec++;
        if (net_out_data !== WIDTH'(exp_out)) begin
          n_err++;
          $display("FAIL b2b_out: got %h, expected %h", net_out_data, exp_out);
        end
        exp_out++;
      end
      tick();
      n_vec++;
      if (send_done !== ((i % 2) == 0)) begin
        n_err++;
        $display("FAIL b2b_done: cycle %0d got %b, expected %b", i, send_done, (i % 2) == 0);
      end
      if (send_done) begin
        caps++;
        send_data = send_data + 1;
      end
    end
    send_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (net_out_valid) begin
        n_vec++;
        if (net_out_data !== WIDTH'(exp_out)) begin
          n_err++;
          $display("FAIL b2b_out: got %h, expected %h", net_out_data, exp_out);
        end
        exp_out++;
      end
      tick();
    end
    net_out_ready = 1'b0;
    n_vec++;
    if (caps != 6 || exp_out != 32'h106 || tx_count !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_total: caps=%0d next=%h cnt=%0d, expected 6 106 0", caps, exp_out, tx_count);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] flags;
    net_out_ready = 1'b0;
    recv_ready    = 1'b0;
    net_in_valid  = 1'b1;
    net_in_data   = 32'hC0;
    tick();
    net_in_data   = 32'hC1;
    tick();
    net_in_valid  = 1'b0;
    for (int w = 0; w < 3; w++) begin
      send_data  = 32'h11 * (w + 1);
      send_ready = 1'b1;
      tick();
      if (w < 2) tick();
    end
    n_vec++;
    if (tx_count !== 3'd3 || rx_count !== 3'd2 || send_done !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: tx=%0d rx=%0d done=%b, expected 3 2 1", tx_count, rx_count, send_done);
    end
    nRST = 1'b0;
    send_ready = 1'b0;
    #1;
    flags = {send_done, recv_valid, net_out_valid, net_in_ready, (recv_data != 0), (net_out_data != 0),
             (tx_count != 0), (rx_count != 0)};
    n_vec++;
    if (flags !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got flags %b, expected 00000000", flags);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    n_vec++;
    if (tx_count !== 3'd0 || rx_count !== 3'd0 || send_done !== 1'b0 || net_in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_after: tx=%0d rx=%0d done=%b rdy=%b, expected 0 0 0 1",
               tx_count, rx_count, send_done, net_in_ready);
    end
    send_data  = 32'h55;
    send_ready = 1'b1;
    tick();
    send_ready = 1'b0;
    n_vec++;
    if (send_done !== 1'b1 || net_out_data !== 32'h55 || tx_count !== 3'd1) begin
      n_err++;
      $display("FAIL mid_new_word: done=%b dat=%h cnt=%0d, expected 1 55 1", send_done, net_out_data, tx_count);
    end
    net_out_ready = 1'b1;
    tick();
    net_out_ready = 1'b0;
    n_vec++;
    if (tx_count !== 3'd0) begin
      n_err++;
      $display("FAIL mid_new_drain: cnt=%0d, expected 0", tx_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_send();
    test_tx_backpressure();
    test_rx_path();
    test_rx_concurrent();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
